// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling sequencer: FSM states, mode encoding
// and the pooled output-dimension function.
package pool_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StBlk,
    StStream,
    StDrain
  } state_e;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // Zero for unusable geometry so the output ports never divide by zero.
  function automatic logic [31:0] out_dim(input logic [31:0] dim, input logic [3:0] win,
                                          input logic [3:0] str);
    if (str == 4'd0 || win == 4'd0 || {28'd0, win} > dim) return 32'd0;
    return (dim - {28'd0, win}) / {28'd0, str} + 32'd1;
  endfunction

endpackage

// File: rtl/pool_win_tracker.sv
// Follows the position of each shifted pixel and flags the pixels that complete
// a pooling window, honouring independent window size and stride per axis.
module pool_win_tracker #(
  parameter int unsigned DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [DIM_W-1:0] wid,
  input  logic [3:0]       win_h,
  input  logic [3:0]       win_v,
  input  logic [3:0]       str_h,
  input  logic [3:0]       str_v,
  output logic             emit
);

  logic [DIM_W-1:0] col_q, row_q;
  logic [3:0]       ph_h_q, ph_v_q;
  logic             h_reach, v_reach, col_last;

  assign h_reach  = (col_q + DIM_W'(1)) >= DIM_W'(win_h);
  assign v_reach  = (row_q + DIM_W'(1)) >= DIM_W'(win_v);
  assign col_last = (col_q == wid - DIM_W'(1));
  assign emit     = adv && h_reach && v_reach && (ph_h_q == 4'd0) && (ph_v_q == 4'd0);

  // Phases start at 0 once a window fits and reload to str-1 after each hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      ph_h_q <= '0;
      ph_v_q <= '0;
    end else if (clr) begin
      col_q  <= '0;
      row_q  <= '0;
      ph_h_q <= '0;
      ph_v_q <= '0;
    end else if (adv) begin
      if (col_last) begin
        col_q  <= '0;
        ph_h_q <= '0;
        row_q  <= row_q + DIM_W'(1);
        if (v_reach) ph_v_q <= (ph_v_q == 4'd0) ? str_v - 4'd1 : ph_v_q - 4'd1;
      end else begin
        col_q <= col_q + DIM_W'(1);
        if (h_reach) ph_h_q <= (ph_h_q == 4'd0) ? str_h - 4'd1 : ph_h_q - 4'd1;
      end
    end
  end

endmodule

// File: rtl/pool_seq_ctrl.sv
// Pooling sequencer: streams BUF1 into the PE array per channel block and writes
// pooled results to BUF2. Define POOL_SEQ_CTRL_PERF_EN for busy/stall counters.
module pool_seq_ctrl
  import pool_pkg::*;
#(
  parameter int unsigned N_PE     = 8,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DIM_W    = 16,
  parameter int unsigned LAT_POOL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic [DIM_W-1:0]  cfg_ch,
  input  logic [DIM_W-1:0]  cfg_wid,
  input  logic [DIM_W-1:0]  cfg_hei,
  input  logic [3:0]        cfg_win_h,
  input  logic [3:0]        cfg_win_v,
  input  logic [3:0]        cfg_str_h,
  input  logic [3:0]        cfg_str_v,
  input  logic              cfg_mode,
  output logic [N_PE-1:0]   buf1_r_en,
  output logic [ADDR_W-1:0] buf1_r_addr,
  output logic [N_PE-1:0]   pe_shift,
  output logic              pe_lb_reset,
  output logic              pool_emit,
  output logic              pool_mode,
  output logic [3:0]        avg_shift,
  output logic [N_PE-1:0]   buf2_w_en,
  output logic [ADDR_W-1:0] buf2_w_addr,
  output logic [DIM_W-1:0]  out_wid,
  output logic [DIM_W-1:0]  out_hei,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
`ifdef POOL_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls
`endif
);

  localparam int unsigned PW    = 2 * DIM_W;
  localparam int unsigned LOG2N = $clog2(N_PE);

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  ch_q, wid_q, hei_q;
  logic [3:0]        win_h_q, win_v_q, str_h_q, str_v_q;
  logic              mode_q;
  logic [DIM_W-1:0]  blk_q, blk_d;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic              err_q, err_d, done_q, done_d, lb_q, shift_q;
  logic [LAT_POOL-1:0] dl_q;
  logic [LAT_POOL:0]   dl_shift;

  logic              load, clr, rd_en, adv, w_fire, dl_empty, cfg_bad;
  logic [7:0]        win_prod;
  logic [PW-1:0]     in_size, out_size;
  logic [DIM_W:0]    ch_round;
  logic [DIM_W-1:0]  cb;
  logic [LOG2N-1:0]  rem;
  logic [N_PE-1:0]   mask;

  assign out_wid  = DIM_W'(out_dim(32'(wid_q), win_h_q, str_h_q));
  assign out_hei  = DIM_W'(out_dim(32'(hei_q), win_v_q, str_v_q));
  assign in_size  = PW'(wid_q) * PW'(hei_q);
  assign out_size = PW'(out_wid) * PW'(out_hei);
  assign ch_round = {1'b0, ch_q} + (DIM_W + 1)'(N_PE - 1);
  assign cb       = DIM_W'(ch_round >> LOG2N);
  assign rem      = ch_q[LOG2N-1:0];
  assign mask     = (blk_q == cb - DIM_W'(1) && rem != '0) ? ~({N_PE{1'b1}} << rem)
                                                           : {N_PE{1'b1}};
  assign win_prod = win_h_q * win_v_q;

  assign cfg_bad = (DIM_W'(win_h_q) > wid_q) || (DIM_W'(win_v_q) > hei_q) ||
                   (win_h_q == 4'd0) || (win_v_q == 4'd0) ||
                   (str_h_q == 4'd0) || (str_v_q == 4'd0) ||
                   (ch_q == '0) || (wid_q == '0) || (hei_q == '0) ||
                   (mode_q == POOL_AVG && (win_prod & (win_prod - 8'd1)) != 8'd0);

  always_comb begin
    avg_shift = 4'd0;
    if (mode_q == POOL_AVG) begin
      for (int i = 0; i < 8; i++) begin
        if (win_prod[i]) avg_shift = 4'(i);
      end
    end
  end

  assign adv      = shift_q & ~stall;
  assign dl_empty = (dl_q == '0);
  assign w_fire   = dl_q[LAT_POOL-1] & ~stall;
  assign dl_shift = {dl_q, pool_emit};

  pool_win_tracker #(
    .DIM_W (DIM_W)
  ) u_tracker (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .adv   (adv),
    .wid   (wid_q),
    .win_h (win_h_q),
    .win_v (win_v_q),
    .str_h (str_h_q),
    .str_v (str_v_q),
    .emit  (pool_emit)
  );

  // Stall freezes every decision; registers simply reload their current value.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    done_d  = 1'b0;
    load    = 1'b0;
    clr     = 1'b0;
    rd_en   = 1'b0;
    if (!stall) begin
      unique case (state_q)
        StIdle: begin
          if (start && !done_q) begin
            load    = 1'b1;
            err_d   = 1'b0;
            state_d = StCheck;
          end
        end
        StCheck: begin
          if (cfg_bad) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            blk_d   = '0;
            state_d = StBlk;
          end
        end
        StBlk: begin
          clr  = 1'b1;
          rd_d = '0;
          wr_d = '0;
          if (blk_q == cb) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StStream;
          end
        end
        StStream: begin
          if (rd_q < in_size) begin
            rd_en = 1'b1;
            rd_d  = rd_q + PW'(1);
          end else begin
            state_d = StDrain;
          end
        end
        StDrain: begin
          if (wr_q == out_size && dl_empty) begin
            blk_d   = blk_q + DIM_W'(1);
            state_d = StBlk;
          end
        end
        default: state_d = StIdle;
      endcase
      if (w_fire) wr_d = wr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      blk_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      lb_q    <= 1'b1;
      shift_q <= 1'b0;
      dl_q    <= '0;
      ch_q    <= '0;
      wid_q   <= '0;
      hei_q   <= '0;
      win_h_q <= '0;
      win_v_q <= '0;
      str_h_q <= '0;
      str_v_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      done_q  <= done_d;
      lb_q    <= (state_d == StBlk);
      if (!stall) begin
        shift_q <= rd_en;
        dl_q    <= dl_shift[LAT_POOL-1:0];
      end
      if (load) begin
        ch_q    <= cfg_ch;
        wid_q   <= cfg_wid;
        hei_q   <= cfg_hei;
        win_h_q <= cfg_win_h;
        win_v_q <= cfg_win_v;
        str_h_q <= cfg_str_h;
        str_v_q <= cfg_str_v;
        mode_q  <= cfg_mode;
      end
    end
  end

  assign buf1_r_en   = rd_en ? mask : '0;
  assign buf1_r_addr = ADDR_W'(PW'(blk_q) * in_size + rd_q);
  assign pe_shift    = adv ? mask : '0;
  assign buf2_w_en   = w_fire ? mask : '0;
  assign buf2_w_addr = ADDR_W'(PW'(blk_q) * out_size + wr_q);
  assign pe_lb_reset = lb_q;
  assign pool_mode   = mode_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign cfg_err     = err_q;

`ifdef POOL_SEQ_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (load) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (busy && stall && perf_stalls != '1) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
